// File: rtl/bram1_frame_ctrl.sv
// Whole-frame write/replay sequencer for a 1-bit-per-pixel dual-port frame BRAM.
// Port A captures a raster-order pixel stream. Port B replays the stored frame
// with x/y coordinates. A read never overlaps a write.
module bram1_frame_ctrl #(
  parameter int unsigned IM_WIDTH     = 320,
  parameter int unsigned IM_HEIGHT    = 240,
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned XY_WIDTH     = 9,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_start,
  input  logic                  in_enable,
  input  logic                  in_data,
  input  logic                  rd_start,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic                  bram_dina,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic                  bram_doutb,
  output logic                  out_enable,
  output logic                  out_data,
  output logic [XY_WIDTH-1:0]   out_x,
  output logic [XY_WIDTH-1:0]   out_y,
  output logic                  wr_busy,
  output logic                  rd_busy,
  output logic                  frame_valid,
  output logic                  wr_done,
  output logic                  rd_done
);

  localparam int unsigned NPix = IM_WIDTH * IM_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NPix - 1);
  localparam logic [XY_WIDTH-1:0]   LastX    = XY_WIDTH'(IM_WIDTH - 1);

  typedef enum logic [1:0] {StWIdle, StWPend, StWRun} w_state_e;
  typedef enum logic [1:0] {StRIdle, StRRun, StRDrain} r_state_e;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                    wea_q, wea_d;
  logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
  logic                    dina_q, dina_d;
  logic [ADDR_WIDTH-1:0]   addrb_q, addrb_d;
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0] last_pipe_q, last_pipe_d;
  logic                    out_enable_q, out_enable_d;
  logic                    out_data_q, out_data_d;
  logic [XY_WIDTH-1:0]     out_x_q, out_x_d;
  logic [XY_WIDTH-1:0]     out_y_q, out_y_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    wr_done_q, wr_done_d;
  logic                    rd_done_q, rd_done_d;

  logic wr_accept, rd_accept, wr_take, wr_last, rd_issue, rd_issue_last;

  // Next-state logic for both FSMs, the address counters and the read pipeline.
  always_comb begin
    // A simultaneous wr_start wins over rd_start.
    wr_accept     = (w_state_q == StWIdle) && wr_start;
    rd_accept     = (r_state_q == StRIdle) && rd_start && frame_valid_q &&
                    (w_state_q == StWIdle) && !wr_start;
    wr_take       = (w_state_q == StWRun) && in_enable;
    wr_last       = wr_take && (wr_addr_q == LastAddr);
    rd_issue      = (r_state_q == StRRun);
    rd_issue_last = rd_issue && (addrb_q == LastAddr);

    w_state_d     = w_state_q;
    r_state_d     = r_state_q;
    wr_addr_d     = wr_addr_q;
    addrb_d       = addrb_q;
    wea_d         = wr_take;
    addra_d       = wr_take ? wr_addr_q : addra_q;
    dina_d        = wr_take ? in_data : dina_q;
    wr_done_d     = wr_last;
    frame_valid_d = frame_valid_q;

    if (wr_accept) begin
      wr_addr_d     = '0;
      frame_valid_d = 1'b0;
    end else if (wr_take) begin
      wr_addr_d = wr_last ? '0 : wr_addr_q + 1'b1;
    end
    if (wr_last) frame_valid_d = 1'b1;

    unique case (w_state_q)
      StWIdle: if (wr_accept) w_state_d = (r_state_q == StRIdle) ? StWRun : StWPend;
      // Idle check covers a request that landed on the rd_done cycle itself.
      StWPend: if (rd_done_q || r_state_q == StRIdle) w_state_d = StWRun;
      StWRun:  if (wr_last) w_state_d = StWIdle;
      default: w_state_d = StWIdle;
    endcase

    unique case (r_state_q)
      StRIdle: begin
        if (rd_accept) begin
          r_state_d = StRRun;
          addrb_d   = '0;
        end
      end
      StRRun: begin
        if (addrb_q == LastAddr) r_state_d = StRDrain;
        else                     addrb_d   = addrb_q + 1'b1;
      end
      // Stay busy through the rd_done cycle so a pending write starts right after.
      StRDrain: if (rd_done_q) r_state_d = StRIdle;
      default:  r_state_d = StRIdle;
    endcase

    // Valid/last flags track each issued address through the BRAM latency.
    vld_pipe_d     = '0;
    last_pipe_d    = '0;
    vld_pipe_d[0]  = rd_issue;
    last_pipe_d[0] = rd_issue_last;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end

    out_enable_d = vld_pipe_q[READ_LATENCY-1];
    out_data_d   = out_enable_d & bram_doutb;
    rd_done_d    = last_pipe_q[READ_LATENCY-1];

    // Coordinates are zero outside the valid stream and start at (0,0).
    out_x_d = '0;
    out_y_d = '0;
    if (out_enable_d && out_enable_q) begin
      if (out_x_q == LastX) begin
        out_y_d = out_y_q + 1'b1;
      end else begin
        out_x_d = out_x_q + 1'b1;
        out_y_d = out_y_q;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q     <= StWIdle;
      r_state_q     <= StRIdle;
      wr_addr_q     <= '0;
      wea_q         <= 1'b0;
      addra_q       <= '0;
      dina_q        <= 1'b0;
      addrb_q       <= '0;
      vld_pipe_q    <= '0;
      last_pipe_q   <= '0;
      out_enable_q  <= 1'b0;
      out_data_q    <= 1'b0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      frame_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      rd_done_q     <= 1'b0;
    end else begin
      w_state_q     <= w_state_d;
      r_state_q     <= r_state_d;
      wr_addr_q     <= wr_addr_d;
      wea_q         <= wea_d;
      addra_q       <= addra_d;
      dina_q        <= dina_d;
      addrb_q       <= addrb_d;
      vld_pipe_q    <= vld_pipe_d;
      last_pipe_q   <= last_pipe_d;
      out_enable_q  <= out_enable_d;
      out_data_q    <= out_data_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      frame_valid_q <= frame_valid_d;
      wr_done_q     <= wr_done_d;
      rd_done_q     <= rd_done_d;
    end
  end

  assign bram_wea    = wea_q;
  assign bram_addra  = addra_q;
  assign bram_dina   = dina_q;
  assign bram_addrb  = addrb_q;
  assign out_enable  = out_enable_q;
  assign out_data    = out_data_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign wr_busy     = (w_state_q != StWIdle);
  assign rd_busy     = (r_state_q != StRIdle);
  assign frame_valid = frame_valid_q;
  assign wr_done     = wr_done_q;
  assign rd_done     = rd_done_q;

endmodule

// File: tb/tb_bram1_frame_ctrl.sv
// Randomised bench for bram1_frame_ctrl on a 4x2 frame with a 1-cycle BRAM.
module tb_bram1_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int L  = 1;
  localparam int AW = 17;
  localparam int XW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_start, in_enable, in_data, rd_start;
  logic          bram_wea, bram_dina, bram_doutb;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic          out_enable, out_data;
  logic [XW-1:0] out_x, out_y;
  logic          wr_busy, rd_busy, frame_valid, wr_done, rd_done;

  always #5 clk = ~clk;

  bram1_frame_ctrl #(
    .IM_WIDTH    (W),
    .IM_HEIGHT   (H),
    .ADDR_WIDTH  (AW),
    .XY_WIDTH    (XW),
    .READ_LATENCY(L)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_start   (wr_start),
    .in_enable  (in_enable),
    .in_data    (in_data),
    .rd_start   (rd_start),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb),
    .out_enable (out_enable),
    .out_data   (out_data),
    .out_x      (out_x),
    .out_y      (out_y),
    .wr_busy    (wr_busy),
    .rd_busy    (rd_busy),
    .frame_valid(frame_valid),
    .wr_done    (wr_done),
    .rd_done    (rd_done)
  );

  // Behavioural dual-port BRAM, one cycle read latency.
  logic ram [N];
  always @(posedge clk) begin
    if (bram_wea) ram[bram_addra[2:0]] <= bram_dina;
    bram_doutb <= ram[bram_addrb[2:0]];
  end

  // Reference model: write mode (0 idle, 1 pending, 2 running), pixels taken,
  // and read phase k = cycles since the read was accepted (0 = no read).
  int m_wmode, m_wcnt, m_rk;
  bit m_fv;
  bit m_mem [N];
  bit e_wea, e_dina, e_wr_done, e_wr_busy, e_fv, e_oen, e_odata, e_rd_done, e_rd_busy;
  int e_addra, e_addrb, e_x, e_y;

  int cyc = 0;
  int pin_wr_t = -1000;
  int pin_rd_t = -1000;
  bit chk_on = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    m_wmode = 0; m_wcnt = 0; m_rk = 0; m_fv = 1'b0;
    e_wea = 0; e_dina = 0; e_wr_done = 0; e_wr_busy = 0; e_fv = 0;
    e_oen = 0; e_odata = 0; e_rd_done = 0; e_rd_busy = 0;
    e_addra = 0; e_addrb = 0; e_x = 0; e_y = 0;
  endtask

  // Advance the model by one clock using the inputs of the cycle just ended.
  task automatic model_step();
    bit rd_idle, rd_last, w_acc, r_acc, take;
    int idx;
    rd_idle = (m_rk == 0);
    rd_last = (m_rk == N + 1 + L);
    w_acc   = (m_wmode == 0) && wr_start;
    r_acc   = rd_idle && rd_start && m_fv && (m_wmode == 0) && !wr_start;
    take    = (m_wmode == 2) && in_enable;

    e_wea     = take;
    e_wr_done = take && (m_wcnt == N - 1);
    if (take) begin
      e_addra = m_wcnt;
      e_dina  = in_data;
      m_mem[m_wcnt] = in_data;
    end

    if (w_acc) begin
      m_wmode = rd_idle ? 2 : 1;
      m_wcnt  = 0;
      m_fv    = 1'b0;
    end else if (m_wmode == 1) begin
      if (rd_last || rd_idle) m_wmode = 2;
    end else if (take) begin
      if (m_wcnt == N - 1) begin
        m_wcnt = 0; m_wmode = 0; m_fv = 1'b1;
      end else begin
        m_wcnt++;
      end
    end

    if (r_acc)         m_rk = 1;
    else if (rd_last)  m_rk = 0;
    else if (!rd_idle) m_rk++;

    e_wr_busy = (m_wmode != 0);
    e_fv      = m_fv;
    e_rd_busy = (m_rk != 0);
    e_rd_done = (m_rk == N + 1 + L);
    if (m_rk >= 1 && m_rk <= N) e_addrb = m_rk - 1;
    e_oen = (m_rk >= 2 + L) && (m_rk <= 1 + L + N);
    if (e_oen) begin
      idx     = m_rk - 2 - L;
      e_x     = idx % W;
      e_y     = idx / W;
      e_odata = m_mem[idx];
    end else begin
      e_x = 0; e_y = 0; e_odata = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Compare process: model on every cycle plus literal pins for the directed frame.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (chk_on) begin
        chk("wea", bram_wea, e_wea);
        if (e_wea) begin
          chk("addra", bram_addra, e_addra);
          chk("dina", bram_dina, e_dina);
        end
        chk("wr_done", wr_done, e_wr_done);
        chk("wr_busy", wr_busy, e_wr_busy);
        chk("frame_valid", frame_valid, e_fv);
        chk("addrb", bram_addrb, e_addrb);
        chk("out_enable", out_enable, e_oen);
        chk("out_data", out_data, e_odata);
        chk("out_x", out_x, e_x);
        chk("out_y", out_y, e_y);
        chk("rd_done", rd_done, e_rd_done);
        chk("rd_busy", rd_busy, e_rd_busy);

        if (cyc == pin_wr_t + 1) begin
          chk("pin_wr_addra", bram_addra, 7);
          chk("pin_wr_dina", bram_dina, 0);
          chk("pin_wr_done", wr_done, 1);
          chk("pin_wr_fv", frame_valid, 1);
        end
        if (cyc == pin_rd_t + 1) chk("pin_addrb0", bram_addrb, 0);
        if (cyc == pin_rd_t + 8) chk("pin_addrb7", bram_addrb, 7);
        if (cyc == pin_rd_t + 2) chk("pin_oen_early", out_enable, 0);
        if (cyc == pin_rd_t + 3) begin
          chk("pin_first_oen", out_enable, 1);
          chk("pin_first_data", out_data, 1);
          chk("pin_first_x", out_x, 0);
          chk("pin_first_y", out_y, 0);
        end
        if (cyc == pin_rd_t + 6) begin
          chk("pin_p3_data", out_data, 1);
          chk("pin_p3_x", out_x, 3);
        end
        if (cyc == pin_rd_t + 7) begin
          chk("pin_p4_data", out_data, 0);
          chk("pin_p4_x", out_x, 0);
          chk("pin_p4_y", out_y, 1);
        end
        if (cyc == pin_rd_t + 9) chk("pin_p6_data", out_data, 1);
        if (cyc == pin_rd_t + 10) begin
          chk("pin_last_done", rd_done, 1);
          chk("pin_last_x", out_x, 3);
          chk("pin_last_y", out_y, 1);
        end
        if (cyc == pin_rd_t + 11) begin
          chk("pin_after_oen", out_enable, 0);
          chk("pin_after_busy", rd_busy, 0);
        end
      end
    end
  end

  task automatic cyc1(input bit ws, input bit rs, input bit ie, input bit id);
    wr_start = ws; rd_start = rs; in_enable = ie; in_data = id;
    @(posedge clk);
    cyc++;
    if (rst_n) model_step();
    else       model_reset();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc1(0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    wr_start = 0; rd_start = 0; in_enable = 0; in_data = 0;
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit pat [N];
    pat = '{1, 0, 1, 1, 0, 0, 1, 0};
    wr_start = 0; rd_start = 0; in_enable = 0; in_data = 0;
    rst_n = 1'b0;
    model_reset();
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Read request with no stored frame.
    cyc1(0, 1, 0, 0);
    idle(20);

    // Directed frame write then replay.
    cyc1(1, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) pin_wr_t = cyc;
      cyc1(0, 0, 1, pat[i]);
    end
    pin_rd_t = cyc;
    cyc1(0, 1, 0, 0);
    idle(12);

    // Gapped write.
    cyc1(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc1(0, 0, (i % 4 == 0) || (i % 4 == 3), 1'($urandom % 2));
    idle(2);

    // Write requested during a read: held pending until the read completes.
    cyc1(0, 1, 0, 0);
    cyc1(0, 0, 1, 1'($urandom % 2));
    cyc1(1, 0, 1, 1'($urandom % 2));
    for (int i = 0; i < 20; i++) cyc1(0, 0, 1, 1'($urandom % 2));
    idle(3);
    cyc1(0, 1, 0, 0);
    idle(12);

    // Reset in the middle of a write.
    cyc1(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc1(0, 0, 1, 1'($urandom % 2));
    pulse_reset();
    cyc1(0, 1, 0, 0);
    idle(15);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) pulse_reset();
      else cyc1($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                1'($urandom % 2), 1'($urandom % 2));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram1_frame_ctrl.md
Name: bram1_frame_ctrl

Overview:
Single-clock sequencer for a 1-bit-per-pixel dual-port frame buffer BRAM: port A write, port B read, default 320x240 = 76800 entries, 17-bit address.
- Write side: captures a raster-order binary pixel stream into port A.
- Read side: replays the stored frame in raster order from port B as a valid-qualified stream with x/y coordinates.
- Arbitrates whole-frame ownership so a read never overlaps a write (no tearing).
- Sits between a binarisation stage and downstream consumers (display or feature stages).

Parameters:
IM_WIDTH, 320, pixels per line
IM_HEIGHT, 240, lines per frame
ADDR_WIDTH, 17, BRAM address width; must satisfy 2^ADDR_WIDTH >= IM_WIDTH*IM_HEIGHT
XY_WIDTH, 9, width of out_x/out_y
READ_LATENCY, 1, BRAM port B clock-to-data latency in cycles

Ports:
clk  in  1  single system clock; BRAM clka and clkb both tied to it
rst_n  in  1  asynchronous active-low reset
wr_start  in  1  one-cycle request to begin capturing a frame
in_enable  in  1  input pixel valid
in_data  in  1  input pixel
rd_start  in  1  one-cycle request to replay the stored frame
bram_wea  out  1  BRAM port A write enable
bram_addra  out  ADDR_WIDTH  BRAM port A address
bram_dina  out  1  BRAM port A data
bram_addrb  out  ADDR_WIDTH  BRAM port B address
bram_doutb  in  1  BRAM port B data
out_enable  out  1  output pixel valid
out_data  out  1  output pixel
out_x  out  XY_WIDTH  column of the current output pixel
out_y  out  XY_WIDTH  row of the current output pixel
wr_busy  out  1  high in W_PEND or W_RUN
rd_busy  out  1  high from rd_start acceptance until rd_done
frame_valid  out  1  a complete frame is stored
wr_done  out  1  one-cycle pulse when the last pixel is written
rd_done  out  1  one-cycle pulse coincident with the last out_enable

Behaviour:
- Reset (async, rst_n=0): all outputs 0, both FSMs idle, all counters 0, frame_valid=0. Reset asserted mid-frame aborts the operation immediately; no done pulse is produced.
- N = IM_WIDTH*IM_HEIGHT. All BRAM-side outputs are registered.
- Write FSM states: W_IDLE, W_PEND, W_RUN.
  - W_IDLE + wr_start: go to W_RUN if the read FSM is idle, else go to W_PEND. In either case clear frame_valid and set wr_addr=0.
  - W_PEND: go to W_RUN on the cycle after rd_done.
  - W_RUN, each cycle with in_enable=1: next cycle bram_wea=1, bram_addra=wr_addr, bram_dina=in_data; wr_addr then increments. When in_enable=0, bram_wea=0 on the next cycle.
  - W_RUN, pixel N-1 accepted: wr_addr wraps to 0, wr_done pulses and frame_valid=1 on the same cycle as its bram_wea, then go to W_IDLE.
  - in_enable outside W_RUN is ignored; bram_wea stays 0.
  - wr_start in W_PEND or W_RUN is ignored.
- Read FSM states: R_IDLE, R_RUN, R_DRAIN.
  - R_IDLE + rd_start: accepted only if frame_valid=1 and the write FSM is in W_IDLE; otherwise ignored with no response.
  - wr_start and rd_start in the same cycle while both FSMs are idle: write wins; rd_start is ignored.
  - R_RUN: bram_addrb = 0,1,...,N-1, one per cycle, no gaps; the first address appears the cycle after acceptance. After N-1 is issued, go to R_DRAIN.
  - R_DRAIN: lasts until the last pixel is output, then go to R_IDLE.
  - bram_addrb holds its last value when idle.
  - rd_start while busy is ignored.
- Read output timing:
  - out_data is registered from bram_doutb.
  - First out_enable is exactly 2+READ_LATENCY cycles after the rd_start cycle (3 with default).
  - out_enable is continuous for N cycles; no backpressure.
  - out_x increments 0..IM_WIDTH-1 then wraps to 0 and increments out_y; out_y runs 0..IM_HEIGHT-1.
  - out_x/out_y are valid only with out_enable and return to 0 after rd_done.
  - out_data=0 when out_enable=0.
- frame_valid remains 1 across any number of reads; only wr_start or reset clears it.

Test Plan:
(Benches use IM_WIDTH=4, IM_HEIGHT=2, N=8 unless noted.)
1. Reset then rd_start=1 -> no out_enable for 20 cycles; rd_busy=0; frame_valid=0.
2. wr_start, then 8 cycles in_enable=1 with data 1,0,1,1,0,0,1,0 -> bram_wea high 8 cycles with addra 0..7 and matching dina; wr_done and frame_valid=1 together with addra=7.
3. After case 2, rd_start at cycle t (BRAM model READ_LATENCY=1) -> bram_addrb 0..7 at t+1..t+8; out_enable t+3..t+10; out_data 1,0,1,1,0,0,1,0; (out_x,out_y) = (0,0)..(3,0),(0,1)..(3,1); rd_done at t+10.
4. Gapped write: in_enable pattern 1,0,0,1,... for 8 pixels -> addra advances only on enabled pixels; wr_done after the 8th accepted pixel.
5. wr_start issued 2 cycles into a read -> wr_busy=1 (W_PEND); write pixels ignored and frame_valid=0 from that cycle; read completes all 8 pixels; W_RUN begins the cycle after rd_done.
6. rst_n pulsed low mid-write (after 3 pixels) -> all outputs 0 immediately; no wr_done; a subsequent rd_start is ignored.
